// File: rtl/uart_rx_deframer.sv
// 8N1 asynchronous serial receiver: recovers a byte per frame from rx_i and
// holds it in a one-entry valid/ready output register with glitch, framing and overrun reporting.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | line idle (high), waiting for a falling edge on rxs
// ST_START | half-bit timer running, start bit re-checked at mid-bit
// ST_DATA  | 8 data bits sampled at mid-bit, LSB first
// ST_STOP  | one bit timer running, stop bit sampled at mid-bit
// ST_BREAK | stop bit read low; wait for the line to return high
module uart_rx_deframer #(
   parameter int CLKS_PER_BIT = 100,
   parameter int SYNC_STAGES  = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       rx_i,
   output logic [7:0] rx_data_o,
   output logic       rx_valid_o,
   input  logic       rx_ready_i,
   output logic       frame_err_o,
   output logic       overrun_o,
   input  logic       err_clr_i,
   output logic       busy_o
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] FULL_LOAD = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] HALF_LOAD = CW'(CLKS_PER_BIT / 2 - 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_STOP,
      ST_BREAK
   } state_t;

   state_t                 state;
   logic [CW-1:0]          cnt;
   logic [2:0]             bit_idx;
   logic [7:0]             shreg;
   logic [SYNC_STAGES-1:0] sync_q;
   logic                   rxs;

   // Synchronizer resets to the idle level so reset release never looks like a start edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '1;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], rx_i};
      end
   end

   assign rxs = sync_q[SYNC_STAGES-1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= ST_IDLE;
         cnt         <= '0;
         bit_idx     <= '0;
         shreg       <= '0;
         rx_data_o   <= 8'h00;
         rx_valid_o  <= 1'b0;
         frame_err_o <= 1'b0;
         overrun_o   <= 1'b0;
         busy_o      <= 1'b0;
      end else begin
         frame_err_o <= 1'b0;
         if (rx_valid_o && rx_ready_i) begin
            rx_valid_o <= 1'b0;
         end
         if (err_clr_i) begin
            overrun_o <= 1'b0;
         end

         case (state)
            ST_IDLE: begin
               if (!rxs) begin
                  state  <= ST_START;
                  cnt    <= HALF_LOAD;
                  busy_o <= 1'b1;
               end
            end

            ST_START: begin
               if (cnt != '0) begin
                  cnt <= cnt - 1'b1;
               end else if (!rxs) begin
                  state   <= ST_DATA;
                  cnt     <= FULL_LOAD;
                  bit_idx <= '0;
               end else begin
                  state  <= ST_IDLE;
                  busy_o <= 1'b0;
               end
            end

            ST_DATA: begin
               if (cnt != '0) begin
                  cnt <= cnt - 1'b1;
               end else begin
                  shreg <= {rxs, shreg[7:1]};
                  cnt   <= FULL_LOAD;
                  if (bit_idx == 3'd7) begin
                     state <= ST_STOP;
                  end else begin
                     bit_idx <= bit_idx + 1'b1;
                  end
               end
            end

            ST_STOP: begin
               if (cnt != '0) begin
                  cnt <= cnt - 1'b1;
               end else if (rxs) begin
                  state  <= ST_IDLE;
                  busy_o <= 1'b0;
                  // A same-cycle accept frees the register, so the new byte may replace the old one.
                  if (!rx_valid_o || rx_ready_i) begin
                     rx_data_o  <= shreg;
                     rx_valid_o <= 1'b1;
                  end else begin
                     overrun_o <= 1'b1;
                  end
               end else begin
                  frame_err_o <= 1'b1;
                  state       <= ST_BREAK;
               end
            end

            ST_BREAK: begin
               if (rxs) begin
                  state  <= ST_IDLE;
                  busy_o <= 1'b0;
               end
            end

            default: begin
               state  <= ST_IDLE;
               busy_o <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_rx_deframer.sv
// Self-checking bench for uart_rx_deframer: serial frames are generated from the byte
// values, and received bytes are compared with the queue of bytes that were sent.
module tb_uart_rx_deframer;

   localparam int CPB  = 16;
   localparam int SYNC = 2;
   localparam int NOM_LAT = (19 * CPB) / 2 + SYNC + 2;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       rx_i = 1'b1;
   logic       rx_ready_i = 1'b1;
   logic       err_clr_i = 1'b0;
   logic [7:0] rx_data_o;
   logic       rx_valid_o;
   logic       frame_err_o;
   logic       overrun_o;
   logic       busy_o;

   uart_rx_deframer #(.CLKS_PER_BIT(CPB), .SYNC_STAGES(SYNC)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .rx_i       (rx_i),
      .rx_data_o  (rx_data_o),
      .rx_valid_o (rx_valid_o),
      .rx_ready_i (rx_ready_i),
      .frame_err_o(frame_err_o),
      .overrun_o  (overrun_o),
      .err_clr_i  (err_clr_i),
      .busy_o     (busy_o)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   // Observed handshakes and pulses, sampled on the falling edge.
   logic [7:0] got_q[$];
   logic [7:0] exp_q[$];
   int v_rises = 0, last_rise = 0, fe_pulses = 0, fe_cycles = 0;
   logic prev_v = 1'b0, prev_fe = 1'b0;

   always @(negedge clk) begin
      if (rx_valid_o && rx_ready_i) got_q.push_back(rx_data_o);
      if (rx_valid_o && !prev_v) begin
         v_rises++;
         last_rise = cyc;
      end
      if (frame_err_o) fe_cycles++;
      if (frame_err_o && !prev_fe) fe_pulses++;
      prev_v  = rx_valid_o;
      prev_fe = frame_err_o;
   end

   int n_assert = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap);
      rx_i = 1'b0;
      tick(CPB);
      for (int i = 0; i < 8; i++) begin
         rx_i = b[i];
         tick(CPB);
      end
      rx_i = 1'b1;
      tick(CPB);
      tick(gap);
   endtask

   task automatic compare_new(input string tag, input int mark);
      check({tag, "_count"}, got_q.size() - mark, exp_q.size());
      for (int i = 0; i < exp_q.size() && mark + i < got_q.size(); i++)
         check($sformatf("%s_byte%0d", tag, i), {24'h0, got_q[mark + i]}, {24'h0, exp_q[i]});
      exp_q.delete();
   endtask

   initial begin
      int mark, t0, lat, rises0, fe0;
      logic [7:0] b;

      // Reset state and idle line
      tick(3);
      check("rst_valid", rx_valid_o, 1'b0);
      check("rst_data", rx_data_o, 8'h00);
      check("rst_busy", busy_o, 1'b0);
      rst_n = 1'b1;
      tick(1000);
      check("idle_valid", rx_valid_o, 1'b0);
      check("idle_busy", busy_o, 1'b0);
      check("idle_rises", v_rises, 0);

      // Single byte with latency
      mark = got_q.size();
      t0 = cyc;
      exp_q.push_back(8'hA5);
      send_byte(8'hA5, 20);
      lat = last_rise - t0;
      check($sformatf("a5_latency_in_range_lat%0d", lat),
            (lat >= NOM_LAT - 1 && lat <= NOM_LAT + 1), 1'b1);
      check("a5_rises", v_rises, 1);
      compare_new("a5", mark);
      check("a5_fe", fe_pulses, 0);

      // Stream 0x00..0xFF, 0x00, 0x01
      mark = got_q.size();
      for (int i = 0; i < 258; i++) begin
         b = 8'(i);
         exp_q.push_back(b);
         send_byte(b, 3 * CPB);
      end
      compare_new("stream", mark);
      check("stream_overrun", overrun_o, 1'b0);
      check("stream_fe", fe_pulses, 0);

      // Random bytes with random idle gaps
      mark = got_q.size();
      for (int i = 0; i < 20; i++) begin
         b = 8'($urandom_range(0, 255));
         exp_q.push_back(b);
         send_byte(b, $urandom_range(0, 40));
      end
      tick(5);
      compare_new("rand", mark);

      // Short glitch, then a long low (break)
      mark = got_q.size();
      rises0 = v_rises;
      rx_i = 1'b0;
      tick(4);
      rx_i = 1'b1;
      check("glitch_busy", busy_o, 1'b1);
      tick(40);
      check("glitch_idle", busy_o, 1'b0);
      check("glitch_fe", fe_pulses, 0);
      check("glitch_rises", v_rises, rises0);
      rx_i = 1'b0;
      tick(200);
      check("break_fe_pulses", fe_pulses, 1);
      check("break_fe_cycles", fe_cycles, 1);
      check("break_busy", busy_o, 1'b1);
      check("break_rises", v_rises, rises0);
      check("break_nobyte", got_q.size(), mark);
      rx_i = 1'b1;
      tick(10);
      check("break_release", busy_o, 1'b0);

      // Overrun with consumer stalled
      rx_ready_i = 1'b0;
      mark = got_q.size();
      send_byte(8'h3C, 20);
      send_byte(8'hC3, 20);
      check("ovr_valid", rx_valid_o, 1'b1);
      check("ovr_data", rx_data_o, 8'h3C);
      check("ovr_flag", overrun_o, 1'b1);
      rx_ready_i = 1'b1;
      err_clr_i  = 1'b1;
      exp_q.push_back(8'h3C);
      tick(1);
      err_clr_i = 1'b0;
      check("ovr_valid_clr", rx_valid_o, 1'b0);
      check("ovr_flag_clr", overrun_o, 1'b0);
      check("ovr_data_hold", rx_data_o, 8'h3C);
      tick(2);
      compare_new("ovr", mark);

      // Reset in the middle of a frame
      fe0 = fe_pulses;
      rx_i = 1'b0;
      tick(CPB);
      for (int i = 0; i < 3; i++) begin
         rx_i = i[0] ? 1'b0 : 1'b1;
         tick(CPB);
      end
      rst_n = 1'b0;
      rx_i  = 1'b1;
      #1;
      check("mid_rst_valid", rx_valid_o, 1'b0);
      check("mid_rst_busy", busy_o, 1'b0);
      check("mid_rst_data", rx_data_o, 8'h00);
      tick(5);
      rst_n = 1'b1;
      tick(20);
      mark = got_q.size();
      exp_q.push_back(8'h81);
      send_byte(8'h81, 20);
      compare_new("post_rst", mark);
      check("post_rst_fe", fe_pulses, fe0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
